// File: rtl/fetch_stage.sv
// fetch_stage -- instruction-fetch stage of the five-stage pipelined CPU.
//
// Holds the fetch PC (PC_F), selects the next PC from the D-stage jump select
// and registers the IF/ID pipeline stage. Branches and jumps resolve in D with
// a one-instruction delay slot, so a redirect never squashes the F-stage fetch.
//
// Optional feature macro: PC_CHECK_EN
//   Defined   -> illegal fetch addresses (misaligned or outside instruction
//                memory) set a sticky pc_err and turn their fetches into nops.
//   Undefined -> no checking, pc_err is tied low.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   stall      in   hold PC_F and IF/ID
//   flush_d    in   load a nop bubble into IF/ID
//   jump_ctrl  in   next-PC select: 00 PC+4, 01 branch, 10 j/jal, 11 jr (RD1)
//   imm16_d    in   D-stage branch offset
//   index26_d  in   D-stage jump target index
//   rs_val_d   in   forwarded rs value (jr target)
//   im_addr    out  instruction memory address (PC_F)
//   im_rdata   in   instruction at im_addr (combinational read)
//   instr_d    out  IF/ID instruction
//   pc_d       out  IF/ID PC
//   pc8_d      out  IF/ID PC+8 (jal link value)
//   valid_d    out  IF/ID holds a real fetched instruction
//   pc_err     out  sticky fetch-address error
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned IM_DEPTH = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush_d,
  input  logic [1:0]  jump_ctrl,
  input  logic [15:0] imm16_d,
  input  logic [25:0] index26_d,
  input  logic [31:0] rs_val_d,
  output logic [31:0] im_addr,
  input  logic [31:0] im_rdata,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc8_d,
  output logic        valid_d,
  output logic        pc_err
);

  typedef enum logic [1:0] {
    SEL_SEQ    = 2'b00,
    SEL_BRANCH = 2'b01,
    SEL_JUMP   = 2'b10,
    SEL_REG    = 2'b11
  } jump_sel_e;

  if (IM_DEPTH == 0) begin : g_bad_depth
    $error("fetch_stage: IM_DEPTH must be nonzero");
  end

  logic [31:0] pc_f_q;
  logic [31:0] instr_q;
  logic [31:0] pc_q;
  logic [31:0] pc8_q;
  logic        valid_q;
  logic [31:0] pc_f_d;
  logic        fetch_bad;
  jump_sel_e   jump_sel;

  assign jump_sel = jump_sel_e'(jump_ctrl);

  always_comb begin
    pc_f_d = pc_f_q + 32'd4;
    unique case (jump_sel)
      SEL_SEQ:    pc_f_d = pc_f_q + 32'd4;
      // Branch offset is relative to the delay-slot address (pc_d + 4).
      SEL_BRANCH: pc_f_d = pc_q + 32'd4 + {{14{imm16_d[15]}}, imm16_d, 2'b00};
      SEL_JUMP:   pc_f_d = {pc_q[31:28], index26_d, 2'b00};
      SEL_REG:    pc_f_d = rs_val_d;
      default:    pc_f_d = pc_f_q + 32'd4;
    endcase
  end

`ifdef PC_CHECK_EN
  localparam logic [32:0] PC_LIMIT = {1'b0, RESET_PC} + 33'(4 * IM_DEPTH);

  logic pc_err_q;
  logic next_bad;

  // 33-bit compare so a memory window ending at 2^32 does not wrap.
  function automatic logic pc_illegal(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (pc < RESET_PC) || ({1'b0, pc} >= PC_LIMIT);
  endfunction

  assign fetch_bad = pc_illegal(pc_f_q);
  assign next_bad  = pc_illegal(pc_f_d);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_err_q <= 1'b0;
    end else if (!stall && next_bad) begin
      pc_err_q <= 1'b1;
    end
  end

  assign pc_err = pc_err_q;
`else
  assign fetch_bad = 1'b0;
  assign pc_err    = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_f_q  <= RESET_PC;
      instr_q <= '0;
      pc_q    <= '0;
      pc8_q   <= '0;
      valid_q <= 1'b0;
    end else if (!stall) begin
      pc_f_q <= pc_f_d;
      if (flush_d || fetch_bad) begin
        instr_q <= '0;
        pc_q    <= '0;
        pc8_q   <= '0;
        valid_q <= 1'b0;
      end else begin
        instr_q <= im_rdata;
        pc_q    <= pc_f_q;
        pc8_q   <= pc_f_q + 32'd8;
        valid_q <= 1'b1;
      end
    end
  end

  assign im_addr = pc_f_q;
  assign instr_d = instr_q;
  assign pc_d    = pc_q;
  assign pc8_d   = pc8_q;
  assign valid_d = valid_q;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the five-stage pipelined CPU: PC register, next-PC select and the IF/ID pipeline register.
- Consumes the 2-bit jump select produced by the D-stage control decoder: 00 adder, 01 Nadder, 10 splitter, 11 RD1.
- Drives the instruction-memory address and hands instruction, PC and PC+8 to the D stage.
- Branch/jump resolve in D with a one-instruction delay slot, so a taken redirect never flushes the F-stage instruction.

Parameters:
- RESET_PC, 32'h00003000, PC value after reset and base of instruction memory
- IM_DEPTH, 4096, instruction memory size in 32-bit words (used only under PC_CHECK_EN)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- stall  in  1  hazard-unit stall; holds the PC and the IF/ID register
- flush_d  in  1  loads a nop bubble into IF/ID
- jump_ctrl  in  2  next-PC select from the D-stage decoder
- imm16_d  in  16  D-stage instruction [15:0], branch offset
- index26_d  in  26  D-stage instruction [25:0], j/jal target
- rs_val_d  in  32  forwarded rs value (RD1), jr target
- im_addr  out  32  current PC (PC_F) to instruction memory
- im_rdata  in  32  instruction at im_addr, combinational read
- instr_d  out  32  IF/ID instruction
- pc_d  out  32  IF/ID PC
- pc8_d  out  32  IF/ID PC+8, link value for jal
- valid_d  out  1  IF/ID holds a real fetched instruction
- pc_err  out  1  sticky fetch-address error (0 when PC_CHECK_EN is undefined)

Behaviour:
- Reset (async, immediate):
  - PC_F = RESET_PC
  - instr_d = 0 (nop), pc_d = 0, pc8_d = 0, valid_d = 0, pc_err = 0
- im_addr = PC_F, combinational.
- Next-PC select, all 32-bit arithmetic, wrap-around ignored:
  - 00: PC_F + 4
  - 01: pc_d + 4 + (sign-extended imm16_d << 2)
  - 10: {pc_d[31:28], index26_d, 2'b00}
  - 11: rs_val_d
- Every rising edge with stall=0:
  - PC_F <= next PC
  - instr_d <= im_rdata; pc_d <= PC_F; pc8_d <= PC_F + 8; valid_d <= 1
- Redirect latency: a redirect selected while the branch is in D takes effect on that edge, so the target is fetched on the following cycle. The instruction fetched in the same cycle as the redirect (the delay slot) proceeds normally.
- stall=1:
  - PC_F and all IF/ID outputs hold.
  - jump_ctrl is ignored; the stalled D instruction re-presents it on a later cycle.
- flush_d=1 with stall=0: PC_F advances normally; IF/ID <= instr 0, pc 0, pc8 0, valid 0.
- stall=1 and flush_d=1 together: stall wins; everything holds.
- jump_ctrl is sampled only at the edge; glitches between edges have no effect.
- Reset asserted mid-operation: async return to reset values. The first fetch after deassertion is at RESET_PC.

Optional Feature:
- Macro: PC_CHECK_EN.
- Defined:
  - A next PC is an error if it has [1:0] != 0, or lies outside [RESET_PC, RESET_PC + 4*IM_DEPTH).
  - On such a non-stalled edge: PC_F still loads the value, pc_err sets sticky until reset, and the instruction captured into IF/ID from that PC is replaced by nop with valid_d=0. This applies to every later fetch while PC_F is illegal.
  - Checking takes no extra cycles.
- Undefined: no checking; pc_err is tied to 0; any PC is fetched as-is.

Test Plan:
- Reset release, im_rdata=32'h3c011234, stall=0, jump_ctrl=00:
  - first edge: instr_d=32'h3c011234, pc_d=32'h3000, pc8_d=32'h3008, valid_d=1
  - PC_F=32'h3004
- Branch taken: pc_d=32'h3010, imm16_d=16'hfffc, jump_ctrl=01 -> next PC_F=32'h3004. The delay slot from 32'h3014 is in IF/ID after the same edge.
- jal then jr:
  - pc_d=32'h3020, index26_d=26'h0000c40, jump_ctrl=10 -> PC_F=32'h3100
  - then jump_ctrl=11, rs_val_d=32'h3028 -> PC_F=32'h3028
- stall=1 for 3 cycles with jump_ctrl=01 -> PC_F, instr_d, pc_d unchanged all 3 cycles. The redirect is applied only on the first edge with stall=0.
- flush_d=1 alone -> instr_d=0, valid_d=0, PC_F advances by 4. stall=1 with flush_d=1 -> no change.
- PC_CHECK_EN defined:
  - jump_ctrl=11, rs_val_d=32'h3002 -> pc_err=1, next instr_d=0, valid_d=0
  - pc_err stays 1 after a legal redirect; clears only on reset
